// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: pops bytes from the keyboard FIFO, tracks
// shift/caps modifiers and presents one ASCII key event at a time.
module ps2_key_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  input  logic       kb_overflow,
  output logic       kb_nextdata_n,
  output logic       key_valid,
  output logic [7:0] key_ascii,
  output logic [7:0] key_code,
  output logic       key_ext,
  input  logic       key_ack,
  output logic       caps_on,
  output logic       shift_on,
  output logic [7:0] key_count,
  output logic       ovf_seen
);

  localparam int unsigned DW     = 8;
  localparam int unsigned HOLD_W = 2;

  localparam logic [DW-1:0] C_BRK    = 8'hF0;
  localparam logic [DW-1:0] C_EXT    = 8'hE0;
  localparam logic [DW-1:0] C_LSHIFT = 8'h12;
  localparam logic [DW-1:0] C_RSHIFT = 8'h59;
  localparam logic [DW-1:0] C_CAPS   = 8'h58;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXTBRK} state_t;

  state_t            r_state, w_state_nxt;
  logic [DW-1:0]     r_byte;
  logic              r_byte_vld;
  logic [HOLD_W-1:0] r_hold;
  logic              r_nextdata_n;
  logic              r_key_valid;
  logic [DW-1:0]     r_key_ascii, r_key_code;
  logic              r_key_ext;
  logic              r_caps_on, r_caps_held, r_lshift, r_rshift, r_shift_on;
  logic [DW-1:0]     r_key_count;
  logic              r_ovf_seen;

  logic              w_accept, w_emit, w_ext, w_upper;
  logic [DW-1:0]     w_ascii;
  logic [2*DW:0]     w_map;
  logic              w_lshift_nxt, w_rshift_nxt, w_caps_nxt, w_caps_held_nxt;

  // {is_letter, plain, shifted}; plain==0 means the code is unmapped.
  function automatic logic [2*DW:0] f_map(input logic [DW-1:0] c);
    case (c)
      8'h1C: f_map = {1'b1, 8'h61, 8'h41};
      8'h32: f_map = {1'b1, 8'h62, 8'h42};
      8'h21: f_map = {1'b1, 8'h63, 8'h43};
      8'h23: f_map = {1'b1, 8'h64, 8'h44};
      8'h24: f_map = {1'b1, 8'h65, 8'h45};
      8'h2B: f_map = {1'b1, 8'h66, 8'h46};
      8'h34: f_map = {1'b1, 8'h67, 8'h47};
      8'h33: f_map = {1'b1, 8'h68, 8'h48};
      8'h43: f_map = {1'b1, 8'h69, 8'h49};
      8'h3B: f_map = {1'b1, 8'h6A, 8'h4A};
      8'h42: f_map = {1'b1, 8'h6B, 8'h4B};
      8'h4B: f_map = {1'b1, 8'h6C, 8'h4C};
      8'h3A: f_map = {1'b1, 8'h6D, 8'h4D};
      8'h31: f_map = {1'b1, 8'h6E, 8'h4E};
      8'h44: f_map = {1'b1, 8'h6F, 8'h4F};
      8'h4D: f_map = {1'b1, 8'h70, 8'h50};
      8'h15: f_map = {1'b1, 8'h71, 8'h51};
      8'h2D: f_map = {1'b1, 8'h72, 8'h52};
      8'h1B: f_map = {1'b1, 8'h73, 8'h53};
      8'h2C: f_map = {1'b1, 8'h74, 8'h54};
      8'h3C: f_map = {1'b1, 8'h75, 8'h55};
      8'h2A: f_map = {1'b1, 8'h76, 8'h56};
      8'h1D: f_map = {1'b1, 8'h77, 8'h57};
      8'h22: f_map = {1'b1, 8'h78, 8'h58};
      8'h35: f_map = {1'b1, 8'h79, 8'h59};
      8'h1A: f_map = {1'b1, 8'h7A, 8'h5A};
      8'h45: f_map = {1'b0, 8'h30, 8'h29};
      8'h16: f_map = {1'b0, 8'h31, 8'h21};
      8'h1E: f_map = {1'b0, 8'h32, 8'h40};
      8'h26: f_map = {1'b0, 8'h33, 8'h23};
      8'h25: f_map = {1'b0, 8'h34, 8'h24};
      8'h2E: f_map = {1'b0, 8'h35, 8'h25};
      8'h36: f_map = {1'b0, 8'h36, 8'h5E};
      8'h3D: f_map = {1'b0, 8'h37, 8'h26};
      8'h3E: f_map = {1'b0, 8'h38, 8'h2A};
      8'h46: f_map = {1'b0, 8'h39, 8'h28};
      8'h29: f_map = {1'b0, 8'h20, 8'h20};
      8'h5A: f_map = {1'b0, 8'h0D, 8'h0D};
      8'h66: f_map = {1'b0, 8'h08, 8'h08};
      default: f_map = '0;
    endcase
  endfunction

  // Holdoff covers the pop cycle and the one after it, while the FIFO head updates.
  assign w_accept = kb_ready && (r_hold == '0) && !r_key_valid;
  assign w_map    = f_map(r_byte);
  assign w_upper  = w_map[2*DW] ? (r_caps_on ^ r_shift_on) : r_shift_on;

  // Parser next-state and event decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_emit           = 1'b0;
    w_ext            = 1'b0;
    w_ascii          = '0;
    w_lshift_nxt     = r_lshift;
    w_rshift_nxt     = r_rshift;
    w_caps_nxt       = r_caps_on;
    w_caps_held_nxt  = r_caps_held;
    if (r_byte_vld) begin
      case (r_state)
        IDLE: begin
          if (r_byte == C_BRK) begin
            w_state_nxt = BRK;
          end else if (r_byte == C_EXT) begin
            w_state_nxt = EXT;
          end else if (r_byte == C_LSHIFT) begin
            w_lshift_nxt = 1'b1;
          end else if (r_byte == C_RSHIFT) begin
            w_rshift_nxt = 1'b1;
          end else if (r_byte == C_CAPS) begin
            // Typematic repeats arrive while held and must not re-toggle.
            if (!r_caps_held) w_caps_nxt = !r_caps_on;
            w_caps_held_nxt = 1'b1;
          end else if (w_map[2*DW-1:DW] != '0) begin
            w_emit  = 1'b1;
            w_ascii = w_upper ? w_map[DW-1:0] : w_map[2*DW-1:DW];
          end
        end
        BRK: begin
          w_state_nxt = IDLE;
          if (r_byte == C_LSHIFT) w_lshift_nxt = 1'b0;
          if (r_byte == C_RSHIFT) w_rshift_nxt = 1'b0;
          if (r_byte == C_CAPS)   w_caps_held_nxt = 1'b0;
        end
        EXT: begin
          if (r_byte == C_BRK) begin
            w_state_nxt = EXTBRK;
          end else begin
            w_state_nxt = IDLE;
            w_emit      = 1'b1;
            w_ext       = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte       <= '0;
      r_byte_vld   <= 1'b0;
      r_hold       <= '0;
      r_nextdata_n <= 1'b1;
      r_key_valid  <= 1'b0;
      r_key_ascii  <= '0;
      r_key_code   <= '0;
      r_key_ext    <= 1'b0;
      r_caps_on    <= 1'b0;
      r_caps_held  <= 1'b0;
      r_lshift     <= 1'b0;
      r_rshift     <= 1'b0;
      r_shift_on   <= 1'b0;
      r_key_count  <= '0;
      r_ovf_seen   <= 1'b0;
    end else begin
      r_nextdata_n <= !w_accept;
      r_byte_vld   <= w_accept;
      if (w_accept)           r_byte <= kb_data;
      if (w_accept)           r_hold <= HOLD_W'(2);
      else if (r_hold != '0)  r_hold <= r_hold - HOLD_W'(1);
      r_lshift    <= w_lshift_nxt;
      r_rshift    <= w_rshift_nxt;
      r_shift_on  <= w_lshift_nxt | w_rshift_nxt;
      r_caps_on   <= w_caps_nxt;
      r_caps_held <= w_caps_held_nxt;
      if (w_emit) begin
        r_key_valid <= 1'b1;
        r_key_ascii <= w_ascii;
        r_key_code  <= r_byte;
        r_key_ext   <= w_ext;
        r_key_count <= r_key_count + DW'(1);
      end else if (r_key_valid && key_ack) begin
        r_key_valid <= 1'b0;
      end
      if (kb_overflow) r_ovf_seen <= 1'b1;
    end
  end

  assign kb_nextdata_n = r_nextdata_n;
  assign key_valid     = r_key_valid;
  assign key_ascii     = r_key_ascii;
  assign key_code      = r_key_code;
  assign key_ext       = r_key_ext;
  assign caps_on       = r_caps_on;
  assign shift_on      = r_shift_on;
  assign key_count     = r_key_count;
  assign ovf_seen      = r_ovf_seen;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: a FIFO model feeds scan codes, a
// prefix-flag reference model predicts events, a monitor checks them.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] kb_data = 8'h00;
  logic       kb_ready = 1'b0;
  logic       kb_overflow = 1'b0;
  logic       kb_nextdata_n;
  logic       key_valid;
  logic [7:0] key_ascii, key_code;
  logic       key_ext;
  logic       key_ack = 1'b0;
  logic       caps_on, shift_on;
  logic [7:0] key_count;
  logic       ovf_seen;

  ps2_key_decoder dut (
    .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready),
    .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n),
    .key_valid(key_valid), .key_ascii(key_ascii), .key_code(key_code),
    .key_ext(key_ext), .key_ack(key_ack), .caps_on(caps_on),
    .shift_on(shift_on), .key_count(key_count), .ovf_seen(ovf_seen)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ascii;
    logic [7:0] code;
    logic       ext;
  } ev_t;

  int errors = 0;
  int checks = 0;
  int pops = 0;
  int ack_mode = 0;
  ev_t exp_q[$];
  byte unsigned fifo_q[$];
  byte unsigned pool[$];

  byte unsigned letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  byte unsigned digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};
  byte unsigned digit_shift[10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E,
    8'h26, 8'h2A, 8'h28};

  // Reference model state: pending prefixes, modifier keys, emitted count.
  bit m_e0, m_f0, m_ls, m_rs, m_caps, m_ch;
  int m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_e0 = 0; m_f0 = 0; m_ls = 0; m_rs = 0; m_caps = 0; m_ch = 0; m_count = 0;
  endfunction

  function automatic void model_push(input byte unsigned a, input byte unsigned c, input bit x);
    ev_t e;
    e.ascii = a; e.code = c; e.ext = x;
    exp_q.push_back(e);
    m_count = (m_count + 1) % 256;
  endfunction

  function automatic void model_byte(input byte unsigned b);
    byte unsigned a;
    bit hit;
    bit sh;
    hit = 0; a = 0;
    sh = m_ls | m_rs;
    if (m_f0) begin
      if (!m_e0) begin
        if (b == 8'h12) m_ls = 0;
        if (b == 8'h59) m_rs = 0;
        if (b == 8'h58) m_ch = 0;
      end
      m_f0 = 0; m_e0 = 0;
    end else if (m_e0) begin
      if (b == 8'hF0) m_f0 = 1;
      else begin model_push(8'h00, b, 1'b1); m_e0 = 0; end
    end else if (b == 8'hF0) m_f0 = 1;
    else if (b == 8'hE0) m_e0 = 1;
    else if (b == 8'h12) m_ls = 1;
    else if (b == 8'h59) m_rs = 1;
    else if (b == 8'h58) begin
      if (!m_ch) m_caps = !m_caps;
      m_ch = 1;
    end else begin
      for (int i = 0; i < 26; i++)
        if (letter_codes[i] == b) begin
          hit = 1;
          a = 8'h61 + 8'(i);
          if (m_caps ^ sh) a = a - 8'h20;
        end
      for (int i = 0; i < 10; i++)
        if (digit_codes[i] == b) begin
          hit = 1;
          a = sh ? digit_shift[i] : 8'h30 + 8'(i);
        end
      if (b == 8'h29) begin hit = 1; a = 8'h20; end
      if (b == 8'h5A) begin hit = 1; a = 8'h0D; end
      if (b == 8'h66) begin hit = 1; a = 8'h08; end
      if (hit) model_push(a, b, 1'b0);
    end
  endfunction

  task automatic send(input byte unsigned b);
    model_byte(b);
    fifo_q.push_back(b);
  endtask

  // FIFO model: pops on the low strobe, presents the new head on the negedge.
  initial begin
    bit prev_low;
    prev_low = 0;
    forever begin
      @(negedge clk);
      if (kb_nextdata_n === 1'b0) begin
        chk("pop_pulse_width", 32'(prev_low), 0);
        chk("pop_nonempty", 32'(fifo_q.size() != 0), 1);
        if (fifo_q.size() != 0) begin
          fifo_q.delete(0);
          pops++;
        end
        prev_low = 1;
      end else begin
        prev_low = 0;
      end
      kb_ready = (fifo_q.size() != 0);
      kb_data  = kb_ready ? fifo_q[0] : 8'h00;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ack_mode)
        0:       key_ack = 1'b1;
        1:       key_ack = ($urandom_range(0, 2) == 0);
        default: key_ack = 1'b0;
      endcase
    end
  end

  // Monitor: new event on valid rise, fields stable while unacked, drop after ack.
  initial begin
    bit pv, pa;
    ev_t held, act, e;
    pv = 0; pa = 0; held = '0;
    forever begin
      @(negedge clk);
      act = {key_ascii, key_code, key_ext};
      if (pv) begin
        if (pa) chk("ack_clears_valid", 32'(key_valid), 0);
        else    chk("event_hold", {15'd0, key_valid, act}, {15'd0, 1'b1, held});
      end else if (key_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: got 0x%0h expected none", act);
        end else begin
          e = exp_q.pop_front();
          chk("event", 32'(act), 32'(e));
        end
        held = act;
      end
      pv = (key_valid === 1'b1);
      pa = (key_ack === 1'b1);
    end
  end

  task automatic drain(input int budget);
    int idle, n;
    idle = 0; n = 0;
    while (idle < 6 && n < budget) begin
      @(negedge clk);
      n++;
      if (fifo_q.size() == 0 && kb_nextdata_n === 1'b1 && key_valid === 1'b0) idle++;
      else idle = 0;
    end
    if (idle < 6) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d cycles expected idle", n);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_shift"}, 32'(shift_on), 32'(m_ls | m_rs));
    chk({tag, "_caps"},  32'(caps_on),  32'(m_caps));
    chk({tag, "_count"}, 32'(key_count), 32'(m_count));
  endtask

  initial begin
    int p0, n;
    foreach (letter_codes[i]) pool.push_back(letter_codes[i]);
    foreach (digit_codes[i])  pool.push_back(digit_codes[i]);
    pool.push_back(8'h29); pool.push_back(8'h5A); pool.push_back(8'h66);
    pool.push_back(8'h12); pool.push_back(8'h59); pool.push_back(8'h58);
    pool.push_back(8'hF0); pool.push_back(8'hF0); pool.push_back(8'hE0);
    pool.push_back(8'h6B); pool.push_back(8'hAA); pool.push_back(8'h0D);
    model_reset();

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_nextdata_n", 32'(kb_nextdata_n), 1);
    chk("rst_key_valid", 32'(key_valid), 0);
    chk("rst_fields", {15'd0, key_ascii, key_code, key_ext}, 0);
    chk("rst_flags", {caps_on, shift_on, ovf_seen}, 0);
    chk("rst_key_count", 32'(key_count), 0);

    // Simple make/break with ack tied high.
    p0 = pops;
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain(200);
    chk("simple_pops", 32'(pops - p0), 3);
    chk("simple_count", 32'(key_count), 1);

    // Shift held across a letter, released before the next.
    send(8'h12); drain(200);
    chk("shift_after_make", 32'(shift_on), 1);
    send(8'h1C); drain(200);
    chk("shift_still_held", 32'(shift_on), 1);
    send(8'hF0); send(8'h12); drain(200);
    chk("shift_after_break", 32'(shift_on), 0);
    send(8'h1C); drain(200);
    check_model("shift_seq");

    // Caps toggle ignores typematic repeat.
    send(8'h58); drain(200);
    chk("caps_first", 32'(caps_on), 1);
    send(8'h58); drain(200);
    chk("caps_repeat", 32'(caps_on), 1);
    send(8'hF0); send(8'h58); send(8'h1C); drain(200);
    check_model("caps_seq");

    // Extended make/break gives one ext event.
    p0 = int'(key_count);
    send(8'hE0); send(8'h6B); send(8'hE0); send(8'hF0); send(8'h6B);
    drain(200);
    chk("ext_events", 32'((int'(key_count) - p0 + 256) % 256), 1);

    // Backpressure: unacked event blocks further pops.
    ack_mode = 2;
    p0 = pops;
    send(8'h16); send(8'h1C);
    n = 0;
    while (key_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(key_valid), 1);
      chk("bp_ascii", 32'(key_ascii), 32'h31);
      chk("bp_nextdata_n", 32'(kb_nextdata_n), 1);
    end
    chk("bp_pops_held", 32'(pops - p0), 1);
    ack_mode = 0;
    drain(200);
    chk("bp_pops_after", 32'(pops - p0), 2);

    // Overflow flag is sticky.
    kb_overflow = 1'b1;
    @(negedge clk);
    kb_overflow = 1'b0;
    @(negedge clk);
    chk("ovf_set", 32'(ovf_seen), 1);

    // Randomised traffic with random acknowledge.
    ack_mode = 1;
    for (int i = 0; i < 400; i++)
      send(pool[$urandom_range(0, pool.size() - 1)]);
    drain(20000);
    check_model("random");
    chk("ovf_sticky", 32'(ovf_seen), 1);

    // Reset during the pop of an E0 prefix discards it.
    ack_mode = 0;
    send(8'hE0);
    n = 0;
    while (kb_nextdata_n !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rstpop_nextdata_n", 32'(kb_nextdata_n), 1);
    chk("rstpop_ovf", 32'(ovf_seen), 0);
    chk("rstpop_caps", 32'(caps_on), 0);
    send(8'h6B);
    drain(200);
    chk("rstpop_no_event", 32'(key_count), 0);

    // 256 events wrap the counter back to zero.
    ack_mode = 1;
    for (int i = 0; i < 256; i++)
      send(letter_codes[$urandom_range(0, 25)]);
    drain(20000);
    chk("count_wrap", 32'(key_count), 0);
    check_model("wrap");

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 The block SHALL have these ports, clock and reset first; one clock, and reset is synchronous and active-high:
 clk  in  1  system clock; all state updates on its rising edge.
 rst  in  1  synchronous active-high reset.
 kb_data  in  8  scan-code byte at the head of the ps2_keyboard FIFO.
 kb_ready  in  1  FIFO non-empty.
 kb_overflow  in  1  FIFO overflow flag.
 kb_nextdata_n  out  1  active-low pop strobe to the FIFO.
 key_valid  out  1  key event pending.
 key_ascii  out  8  ASCII of the event; 0x00 if none.
 key_code  out  8  raw make code of the event.
 key_ext  out  1  event was E0-prefixed.
 key_ack  in  1  downstream consumes the event.
 caps_on  out  1  caps-lock state, for the LED.
 shift_on  out  1  either shift key held.
 key_count  out  8  count of emitted events.
 ovf_seen  out  1  sticky overflow flag.

Function
REQ-002 Byte accept SHALL happen at an edge where kb_ready=1, no pop is in flight, and key_valid=0 (backpressure); kb_data SHALL be captured at that edge.
REQ-003 kb_nextdata_n SHALL be registered: low for exactly the one cycle after the accept edge, otherwise high; kb_ready SHALL be ignored during that cycle and the next.
REQ-004 Parser FSM states SHALL be IDLE, BRK (F0 seen), EXT (E0 seen), EXTBRK (E0 F0 seen), with these transitions:
 - IDLE: F0->BRK, E0->EXT, other->IDLE;
 - EXT: F0->EXTBRK, other->IDLE;
 - BRK, EXTBRK: any byte->IDLE.
REQ-005 In IDLE, 0x12 (left shift) and 0x59 (right shift) SHALL set their held flags; in BRK they SHALL clear them; shift_on = OR of both flags.
REQ-006 In IDLE, 0x58 SHALL toggle caps_on only if caps_held=0, then set caps_held; in BRK, 0x58 SHALL clear caps_held, so typematic repeats do not toggle.
REQ-007 Modifier codes (0x12, 0x59, 0x58) and all break codes (BRK, EXTBRK) SHALL produce no event.
REQ-008 Other codes in IDLE SHALL raise key_valid on the next edge with key_code=byte and key_ext=0, for mapped keys only. key_ascii mapping:
 - letters: lowercase, or uppercase when caps_on XOR shift_on;
 - digits: 0-9, or !@#$%^&*() with shift;
 - 0x29 -> 0x20; 0x5A -> 0x0D; 0x66 -> 0x08.
 Unmapped non-modifier codes SHALL be dropped silently.
REQ-009 Any byte in EXT other than F0 SHALL emit an event with key_ext=1, key_ascii=0x00, key_code=byte.
REQ-010 key_valid and the key_* fields SHALL hold stable until an edge with key_ack=1; key_valid SHALL be 0 from the next cycle; key_ack while key_valid=0 SHALL be ignored.
REQ-011 Event latency SHALL be one clock from the accept edge of the final byte to key_valid=1.
REQ-012 key_count SHALL increment by 1 on each event emission and wrap 255->0.
REQ-013 ovf_seen SHALL set on any cycle with kb_overflow=1 and clear only on rst.
REQ-014 Typematic repeats (same make code repeated) SHALL each emit one event.

Reset
REQ-015 While rst=1 at an edge, the block SHALL set:
 - kb_nextdata_n=1, key_valid=0;
 - key_ascii, key_code, key_ext to 0;
 - caps_on, caps_held, both shift flags, key_count, ovf_seen to 0;
 - FSM to IDLE.
REQ-016 Reset mid-sequence (after E0 or F0) SHALL discard the prefix; reset during a pop SHALL leave kb_nextdata_n=1 from the next cycle.

Verification
REQ-017 FIFO bytes 1C, F0, 1C, ack tied 1 -> one event: ascii 0x61, code 0x1C, ext 0, key_count=1; three pops, each kb_nextdata_n low exactly one cycle.
REQ-018 Bytes 12, 1C, F0, 12, 1C -> events 0x41, then 0x61; shift_on is 1 between the 12 make and the F0 12 break.
REQ-019 Bytes 58, 58, F0, 58, 1C -> caps_on=1 after the first 58, unchanged by the repeat; the event is 0x41.
REQ-020 Bytes E0, 6B, E0, F0, 6B -> exactly one event: ext=1, code 0x6B, ascii 0x00.
REQ-021 Event 16 with key_ack held 0 for 10 cycles while kb_ready=1 -> key_valid held with ascii 0x31, kb_nextdata_n stays 1; after the ack the next byte is popped.
REQ-022 Bytes E0 then rst pulse then 6B -> no ext event; kb_overflow pulse -> ovf_seen=1 until rst; 256 events -> key_count wraps to 0.
